// File: rtl/ps2_keypad_pkg.sv
// Shared constants for the PS/2 keypad slice: receiver state encoding and scan codes.
// Direction masks are ordered {up, down, left, right}.
package ps2_keypad_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_UP    = 8'h75;
    localparam logic [7:0] CODE_DOWN  = 8'h72;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;
    localparam logic [7:0] CODE_W     = 8'h1D;
    localparam logic [7:0] CODE_S     = 8'h1B;
    localparam logic [7:0] CODE_A     = 8'h1C;
    localparam logic [7:0] CODE_D     = 8'h23;

    function automatic logic [3:0] arrow_mask(input logic [7:0] scan);
        case (scan)
            CODE_UP:    arrow_mask = 4'b1000;
            CODE_DOWN:  arrow_mask = 4'b0100;
            CODE_LEFT:  arrow_mask = 4'b0010;
            CODE_RIGHT: arrow_mask = 4'b0001;
            default:    arrow_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [3:0] wasd_mask(input logic [7:0] scan);
        case (scan)
            CODE_W:  wasd_mask = 4'b1000;
            CODE_S:  wasd_mask = 4'b0100;
            CODE_A:  wasd_mask = 4'b0010;
            CODE_D:  wasd_mask = 4'b0001;
            default: wasd_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: input synchronisers, ps2_clk falling-edge detect, 11-bit frame FSM
// and inactivity timeout. byte_ok/byte_err are single-cycle strobes aligned with the STOP edge.
module ps2_rx
    import ps2_keypad_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_ok,
    output logic       byte_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_prev;
    logic [1:0]    state;
    logic [7:0]    shift_reg;
    logic [2:0]    bit_cnt;
    logic          parity_bit;
    logic [TW-1:0] timeout_cnt;
    logic          fall;
    logic          sample;
    logic          frame_good;
    logic          timeout_hit;

    // Synchronisers reset to 1 so an idle bus never looks like a falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall        = clk_prev & ~clk_sync[1];
    assign sample      = data_sync[1];
    assign frame_good  = sample & (^{shift_reg, parity_bit});
    assign timeout_hit = (state != ST_IDLE) && !fall && (timeout_cnt >= TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt <= '0;
        end else if (fall || state == ST_IDLE) begin
            timeout_cnt <= '0;
        end else if (timeout_cnt != TW'(TIMEOUT_CYCLES)) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shift_reg  <= 8'h00;
            bit_cnt    <= 3'd0;
            parity_bit <= 1'b0;
        end else if (timeout_hit) begin
            state   <= ST_IDLE;
            bit_cnt <= 3'd0;
        end else if (fall) begin
            case (state)
                ST_IDLE: begin
                    if (!sample) begin
                        state   <= ST_DATA;
                        bit_cnt <= 3'd0;
                    end
                end
                ST_DATA: begin
                    shift_reg <= {sample, shift_reg[7:1]};
                    bit_cnt   <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state <= ST_PARITY;
                end
                ST_PARITY: begin
                    parity_bit <= sample;
                    state      <= ST_STOP;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rx_byte  = shift_reg;
    assign byte_ok  = fall && (state == ST_STOP) && frame_good;
    assign byte_err = (fall && (state == ST_STOP) && !frame_good) || timeout_hit;

endmodule

// File: rtl/ps2_keypad.sv
// PS/2 keyboard to direction-key decoder with E0/F0 prefix tracking and per-key hold registers.
// Define PS2_KEYPAD_WASD_EN to make W/S/A/D drive the same outputs as the arrow keys.
module ps2_keypad
    import ps2_keypad_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 25000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       up,
    output logic       down,
    output logic       left,
    output logic       right,
    output logic [7:0] code,
    output logic       code_valid,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       byte_ok;
    logic       byte_err;
    logic       ext_flag;
    logic       brk_flag;
    logic       is_prefix;
    logic       key_byte;
    logic [3:0] arrow_hold;
    logic [3:0] dir_hold;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .rx_byte  (rx_byte),
        .byte_ok  (byte_ok),
        .byte_err (byte_err)
    );

    assign is_prefix = (rx_byte == CODE_EXT) || (rx_byte == CODE_BRK);
    assign key_byte  = byte_ok && !is_prefix;

    // A bad frame drops any pending prefixes so the next key sequence starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_flag   <= 1'b0;
            brk_flag   <= 1'b0;
            code       <= 8'h00;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= byte_err;
            if (byte_err) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (byte_ok) begin
                if (rx_byte == CODE_EXT) begin
                    ext_flag <= 1'b1;
                end else if (rx_byte == CODE_BRK) begin
                    brk_flag <= 1'b1;
                end else begin
                    code       <= rx_byte;
                    code_valid <= 1'b1;
                    ext_flag   <= 1'b0;
                    brk_flag   <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arrow_hold <= 4'b0000;
        end else if (key_byte && ext_flag) begin
            arrow_hold <= brk_flag ? (arrow_hold & ~arrow_mask(rx_byte))
                                   : (arrow_hold |  arrow_mask(rx_byte));
        end
    end

`ifdef PS2_KEYPAD_WASD_EN
    logic [3:0] wasd_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wasd_hold <= 4'b0000;
        end else if (key_byte && !ext_flag) begin
            wasd_hold <= brk_flag ? (wasd_hold & ~wasd_mask(rx_byte))
                                  : (wasd_hold |  wasd_mask(rx_byte));
        end
    end

    assign dir_hold = arrow_hold | wasd_hold;
`else
    assign dir_hold = arrow_hold;
`endif

    assign {up, down, left, right} = dir_hold;

endmodule

// File: tb/tb_ps2_keypad.sv
// Randomised and directed bench for ps2_keypad against a key-event reference model.
// Honours PS2_KEYPAD_WASD_EN the same way the design does.
module tb_ps2_keypad;

    localparam int TIMEOUT = 100;
    localparam int HALF    = 10;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       up, down, left, right;
    logic [7:0] code;
    logic       code_valid, frame_err;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int cv_count = 0;
    int fe_count = 0;
    int last_cv_cycle = 0;
    int stop_cycle    = 0;

    // Reference model state: pending prefixes, held keys, last code and pulse totals.
    bit         m_ext, m_brk;
    bit   [3:0] m_arrow, m_wasd;
    logic [7:0] m_code;
    int         m_cv, m_fe;

    ps2_keypad #(
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .up         (up),
        .down       (down),
        .left       (left),
        .right      (right),
        .code       (code),
        .code_valid (code_valid),
        .frame_err  (frame_err)
    );

    always #20 clk = ~clk;

    always @(negedge clk) begin
        cycle = cycle + 1;
        if (code_valid) begin
            cv_count      = cv_count + 1;
            last_cv_cycle = cycle;
        end
        if (frame_err) fe_count = fe_count + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks = checks + 1;
        if (observed !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_frame(input logic [7:0] b, input bit ok);
        if (!ok) begin
            m_ext = 0; m_brk = 0; m_fe++;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            m_code = b;
            m_cv++;
            if (m_ext) begin
                case (b)
                    8'h75: m_arrow[3] = !m_brk;
                    8'h72: m_arrow[2] = !m_brk;
                    8'h6B: m_arrow[1] = !m_brk;
                    8'h74: m_arrow[0] = !m_brk;
                    default: ;
                endcase
            end
`ifdef PS2_KEYPAD_WASD_EN
            else begin
                case (b)
                    8'h1D: m_wasd[3] = !m_brk;
                    8'h1B: m_wasd[2] = !m_brk;
                    8'h1C: m_wasd[1] = !m_brk;
                    8'h23: m_wasd[0] = !m_brk;
                    default: ;
                endcase
            end
`endif
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic check_state(input string tag);
        logic [3:0] dirs;
        dirs = m_arrow | m_wasd;
        checkOutput({tag, ".up"},    up,       dirs[3]);
        checkOutput({tag, ".down"},  down,     dirs[2]);
        checkOutput({tag, ".left"},  left,     dirs[1]);
        checkOutput({tag, ".right"}, right,    dirs[0]);
        checkOutput({tag, ".code"},  code,     m_code);
        checkOutput({tag, ".cv"},    cv_count, m_cv);
        checkOutput({tag, ".fe"},    fe_count, m_fe);
    endtask

    // Frame bits in wire order: start, 8 data LSB first, odd parity, stop.
    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            #1;
            ps2_clk    = 1'b0;
            stop_cycle = cycle;
            repeat (HALF) @(negedge clk);
            #1;
            ps2_clk = 1'b1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        bit ok;
        int cv_before;
        ok        = !bad_par && !bad_stop;
        cv_before = cv_count;
        send_bits(frame_bits(b, bad_par, bad_stop), 11);
        ps2_data = 1'b1;
        repeat (2 * HALF) @(negedge clk);
        model_frame(b, ok);
        if (ok && b != 8'hE0 && b != 8'hF0 && cv_count != cv_before)
            checkOutput("latency", last_cv_cycle - stop_cycle, 3);
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_arrow = 4'b0; m_wasd = 4'b0; m_code = 8'h00;
    endtask

    initial begin
        logic [7:0] pool [13];
        logic [7:0] b;
        int         sel, r, fe_before;

        pool = '{8'hE0, 8'hE0, 8'hF0, 8'h75, 8'h72, 8'h6B, 8'h74,
                 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'hAA, 8'hFA};
        model_reset();
        m_cv = 0; m_fe = 0;

        repeat (5) @(negedge clk);
        checkOutput("rst.dirs", {up, down, left, right}, 4'b0000);
        checkOutput("rst.code", code, 8'h00);
        checkOutput("rst.pulses", {code_valid, frame_err}, 2'b00);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Bad parity first: nothing but one frame_err.
        applyStimulus(8'h75, 1, 0);
        check_state("badpar");
        checkOutput("badpar.code00", code, 8'h00);
        applyStimulus(8'hE0, 0, 0); applyStimulus(8'h72, 0, 0);
        checkOutput("down_after_err", down, 1'b1);
        check_state("down");
        applyStimulus(8'hE0, 0, 0); applyStimulus(8'hF0, 0, 0); applyStimulus(8'h72, 0, 0);

        applyStimulus(8'hE0, 0, 0); applyStimulus(8'h75, 0, 0);
        checkOutput("up_make", up, 1'b1);
        checkOutput("up_code", code, 8'h75);
        check_state("up_make");
        applyStimulus(8'hE0, 0, 0); applyStimulus(8'hF0, 0, 0); applyStimulus(8'h75, 0, 0);
        checkOutput("up_break", up, 1'b0);

        applyStimulus(8'hE0, 0, 0); applyStimulus(8'h6B, 0, 0);
        applyStimulus(8'hE0, 0, 0); applyStimulus(8'h74, 0, 0);
        checkOutput("lr_both", {left, right}, 2'b11);
        applyStimulus(8'hE0, 0, 0); applyStimulus(8'hF0, 0, 0); applyStimulus(8'h6B, 0, 0);
        checkOutput("lr_rel_left", {left, right}, 2'b01);
        check_state("lr");

        applyStimulus(8'h75, 0, 0);
        checkOutput("keypad8_not_up", up, 1'b0);
        applyStimulus(8'hE0, 0, 1);
        check_state("badstop");

        // Partial frame then a silent bus: exactly one timeout error, not early.
        fe_before = fe_count;
        send_bits(frame_bits(8'h75, 0, 0), 5);
        repeat (TIMEOUT - HALF - 10) @(negedge clk);
        checkOutput("timeout_early", fe_count, fe_before);
        repeat (30 + TIMEOUT) @(negedge clk);
        checkOutput("timeout_once", fe_count, fe_before + 1);
        model_frame(8'h00, 0);
        applyStimulus(8'hAA, 0, 0);
        checkOutput("after_timeout_code", code, 8'hAA);
        check_state("timeout");

        // Reset in the middle of a frame with up held.
        applyStimulus(8'hE0, 0, 0); applyStimulus(8'h75, 0, 0);
        checkOutput("pre_rst_up", up, 1'b1);
        applyStimulus(8'hE0, 0, 0);
        send_bits(frame_bits(8'h75, 0, 0), 5);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("midrst.dirs", {up, down, left, right}, 4'b0000);
        checkOutput("midrst.code", code, 8'h00);
        model_reset();
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        applyStimulus(8'hE0, 0, 0); applyStimulus(8'h75, 0, 0);
        checkOutput("post_rst_up", up, 1'b1);
        check_state("post_rst");

        applyStimulus(8'h1D, 0, 0);
`ifdef PS2_KEYPAD_WASD_EN
        checkOutput("wasd_make", up, 1'b1);
        applyStimulus(8'hE0, 0, 0); applyStimulus(8'hF0, 0, 0); applyStimulus(8'h75, 0, 0);
        checkOutput("wasd_or_arrow", up, 1'b1);
        applyStimulus(8'hF0, 0, 0); applyStimulus(8'h1D, 0, 0);
        checkOutput("wasd_break", up, 1'b0);
`else
        checkOutput("w_code", code, 8'h1D);
        applyStimulus(8'hE0, 0, 0); applyStimulus(8'hF0, 0, 0); applyStimulus(8'h75, 0, 0);
        checkOutput("w_unmapped", up, 1'b0);
`endif
        check_state("wasd");

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 13);
            if (sel == 13) b = 8'($urandom_range(0, 255));
            else           b = pool[sel];
            r = $urandom_range(0, 19);
            applyStimulus(b, r == 0, r == 1);
            check_state($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
